// File: rtl/div_mul_recon_if.sv
// Operand/result handshake bundle for the dividend reconstruction unit.
// master = producer/consumer side, slave = the reconstruction unit.
interface div_mul_recon_if #(
  parameter int QW = 16,
  parameter int BW = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [QW-1:0]     quot;
  logic [BW-1:0]     divisor;
  logic [QW-1:0]     rem;
  logic              out_valid;
  logic              out_ready;
  logic [QW+BW-1:0]  dividend;
  logic              fits16;
  logic              rem_err;

  modport master (
    output in_valid, quot, divisor, rem, out_ready,
    input  in_ready, out_valid, dividend, fits16, rem_err
  );

  modport slave (
    input  in_valid, quot, divisor, rem, out_ready,
    output in_ready, out_valid, dividend, fits16, rem_err
  );
endinterface

// File: rtl/div_mul_recon.sv
// Rebuilds dividend = quot*divisor + rem with a shift-add multiplier that
// consumes one divisor bit per cycle (BW cycles per operation).
module div_mul_recon #(
  parameter int QW = 16,
  parameter int BW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  div_mul_recon_if.slave bus
);
  localparam int RW = QW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [QW-1:0]   quot_reg;
  logic [BW-1:0]   divisor_reg;
  logic [RW-1:0]   acc_reg, acc_next;
  logic [CW-1:0]   cnt_reg;
  logic            fits16_reg;
  logic            rem_err_reg;
  logic            accept;
  logic            last_step;
  logic            in_ready;
  logic            out_valid;
  logic [RW-1:0]   pp [BW];

  // Partial product for each divisor bit; the step counter selects one per cycle.
  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_pp
      assign pp[gi] = divisor_reg[gi] ? (RW'(quot_reg) << gi) : '0;
    end
  endgenerate

  assign acc_next = acc_reg + pp[cnt_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == CW'(BW - 1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quot_reg    <= '0;
      divisor_reg <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      fits16_reg  <= 1'b0;
      rem_err_reg <= 1'b0;
    end else if (accept) begin
      quot_reg    <= bus.quot;
      divisor_reg <= bus.divisor;
      acc_reg     <= RW'(bus.rem);
      cnt_reg     <= '0;
      fits16_reg  <= 1'b0;
      rem_err_reg <= (bus.divisor == '0) || (RW'(bus.rem) >= RW'(bus.divisor));
    end else if (state_reg == CALC) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CW'(1);
      // Upper-half check uses the final sum so it is ready together with out_valid.
      if (last_step) begin
        fits16_reg <= (acc_next[RW-1:QW] == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dividend  = acc_reg;
  assign bus.fits16    = fits16_reg;
  assign bus.rem_err   = rem_err_reg;
endmodule

// File: tb/tb_div_mul_recon.sv
// Directed and randomized checks of div_mul_recon: latency, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_div_mul_recon;
  localparam int QW = 16;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_mul_recon_if #(.QW(QW), .BW(BW)) bus ();

  div_mul_recon #(.QW(QW), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [15:0] q, input logic [7:0] d, input logic [15:0] r);
    bus.quot     = q;
    bus.divisor  = d;
    bus.rem      = r;
    bus.in_valid = 1'b1;
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_directed(input string tag, input logic [15:0] q, input logic [7:0] d,
                              input logic [15:0] r, input logic [23:0] exp_div,
                              input logic exp_fit, input logic exp_err);
    int n;
    accept_op(q, d, r);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_dividend"}, 32'(bus.dividend), 32'(exp_div));
    check({tag, "_fits16"}, 32'(bus.fits16), 32'(exp_fit));
    check({tag, "_rem_err"}, 32'(bus.rem_err), 32'(exp_err));
    $display("op %s q=%0d d=%0d r=%0d dividend=0x%06h fits16=%0b rem_err=%0b",
             tag, q, d, r, bus.dividend, bus.fits16, bus.rem_err);
    tick();
    check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int unsigned acc_cyc;
    int unsigned prev_cyc;
    logic [15:0] q;
    logic [7:0]  d;
    logic [15:0] r;
    logic [23:0] exp_div;
    logic        saw_valid;

    bus.in_valid  = 1'b0;
    bus.quot      = '0;
    bus.divisor   = '0;
    bus.rem       = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dividend", 32'(bus.dividend), 32'd0);
    check("rst_fits16", 32'(bus.fits16), 32'd0);
    check("rst_rem_err", 32'(bus.rem_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_directed("basic", 16'd142, 8'd7, 16'd6, 24'h0003E8, 1'b1, 1'b0);
    run_directed("max", 16'hFFFF, 8'hFF, 16'hFFFF, 24'hFFFF00, 1'b0, 1'b1);
    run_directed("div0", 16'd5, 8'd0, 16'd3, 24'd3, 1'b1, 1'b1);

    // Backpressure: result held for 5 cycles while a new operand set is offered.
    bus.out_ready = 1'b0;
    accept_op(16'd1000, 8'd3, 16'd2);
    wait_done(n);
    check("bp_latency", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.quot     = 16'd7;
      bus.divisor  = 8'd7;
      bus.rem      = 16'd7;
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_dividend", 32'(bus.dividend), 32'd3002);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    check("bp_no_accept", 32'(bus.dividend), 32'd3002);
    $display("op backpressure q=1000 d=3 r=2 dividend=0x%06h", bus.dividend);

    // Reset lands on the 4th CALC cycle; nothing may come out afterwards.
    accept_op(16'h1234, 8'h55, 16'h0010);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_dividend", 32'(bus.dividend), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_rem_err", 32'(bus.rem_err), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", 32'(saw_valid), 32'd0);
    $display("op midreset discarded");
    run_directed("after_rst", 16'd1, 8'd1, 16'd0, 24'd1, 1'b1, 1'b0);

    // Back-to-back random operations with out_ready held high.
    prev_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      q = 16'($urandom);
      d = 8'($urandom);
      r = (i % 2 == 1) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      exp_div = 24'(longint'(q) * longint'(d) + longint'(r));
      n = 0;
      while (!bus.in_ready && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) check("rnd_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.quot     = q;
      bus.divisor  = d;
      bus.rem      = r;
      bus.in_valid = 1'b1;
      tick();
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      if (i > 0) check("rnd_spacing", 32'(acc_cyc - prev_cyc), 32'd10);
      prev_cyc = acc_cyc;
      wait_done(n);
      check("rnd_latency", 32'(n), 32'd8);
      check("rnd_dividend", 32'(bus.dividend), 32'(exp_div));
      check("rnd_fits16", 32'(bus.fits16), 32'(exp_div[23:16] == 8'd0));
      check("rnd_rem_err", 32'(bus.rem_err), 32'((d == 8'd0) || (r >= 16'(d))));
      $display("op rnd%0d q=%0d d=%0d r=%0d dividend=0x%06h expected=0x%06h",
               i, q, d, r, bus.dividend, exp_div);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
